spec_acc_param: RTL and testbench

Parametrised power-spectrum integrator placed after the FFT/power stage in the DDC pulsar chain. It sums exactly num_acc consecutive spectra bin-by-bin in an internal dual-port RAM and streams out the integrated spectrum during the last frame of each integration. This block corrects the first-integration off-by-one of the previous accumulator. It adds generic widths and depth, gapped input, clean frame alignment after reset, and an integration counter.

---
 rtl/spec_acc_param.sv | 131 +++++++++++++
 tb/tb_spec_acc_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spec_acc_param.sv
// rtl/spec_acc_param.sv - bin-wise power-spectrum integrator over num_acc frames, 2-cycle latency.
// Optional macro ACC_SAT_EN: saturate the accumulator instead of wrapping.
module spec_acc_param #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  num_acc,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_bin,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic [ADDR_W-1:0] out_bin,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  int_cnt
);

  logic [ACC_W-1:0] mem [2**ADDR_W];
  logic [ACC_W-1:0] ram_q;

  logic             aligned;
  logic [CNT_W-1:0] frame_idx;
  logic [CNT_W-1:0] n_lat;

  logic             sof_in;
  logic             start_int;
  logic             accept;
  logic [CNT_W-1:0] cur_idx;
  logic [CNT_W-1:0] cur_n;

  // Frame position of the sample currently presented, including the effect of its own bin 0.
  always_comb begin
    sof_in    = in_valid && (in_bin == '0);
    start_int = sof_in && (!aligned || (frame_idx == n_lat - CNT_W'(1)));
    accept    = in_valid && (aligned || sof_in);
    cur_idx   = frame_idx;
    cur_n     = n_lat;
    if (start_int) begin
      cur_idx = '0;
      cur_n   = (num_acc == '0) ? CNT_W'(1) : num_acc;
    end else if (sof_in) begin
      cur_idx = frame_idx + CNT_W'(1);
    end
  end

  logic              v1;
  logic              first1;
  logic              last1;
  logic [ADDR_W-1:0] bin1;
  logic [DATA_W-1:0] data1;

  always_ff @(posedge clk) begin
    ram_q <= mem[in_bin];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aligned   <= 1'b0;
      frame_idx <= '0;
      n_lat     <= '0;
      v1        <= 1'b0;
      first1    <= 1'b0;
      last1     <= 1'b0;
      bin1      <= '0;
      data1     <= '0;
    end else begin
      v1     <= accept;
      first1 <= (cur_idx == '0);
      last1  <= (cur_idx == cur_n - CNT_W'(1));
      bin1   <= in_bin;
      data1  <= in_data;
      if (accept) begin
        aligned   <= 1'b1;
        frame_idx <= cur_idx;
        n_lat     <= cur_n;
      end
    end
  end

  logic [ACC_W-1:0] sum;
`ifdef ACC_SAT_EN
  logic [ACC_W:0] raw;
  always_comb begin
    raw = first1 ? {1'b0, ACC_W'(data1)} : ({1'b0, ram_q} + {1'b0, ACC_W'(data1)});
    sum = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
  end
`else
  always_comb begin
    sum = first1 ? ACC_W'(data1) : (ram_q + ACC_W'(data1));
  end
`endif

  logic              v2;
  logic [ADDR_W-1:0] bin2;
  logic [ACC_W-1:0]  sum2;
  logic              emit;

  assign emit = v1 && last1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      bin2      <= '0;
      sum2      <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_bin   <= '0;
      out_data  <= '0;
      int_cnt   <= '0;
    end else begin
      v2        <= v1;
      bin2      <= bin1;
      sum2      <= sum;
      out_valid <= emit;
      out_sof   <= emit && (bin1 == '0);
      out_bin   <= emit ? bin1 : '0;
      out_data  <= emit ? sum : '0;
      int_cnt   <= int_cnt + CNT_W'(out_valid && out_sof);
    end
  end

  // Frames are at least 3 samples long, so this write always lands before the next read of the bin.
  always_ff @(posedge clk) begin
    if (v2) mem[bin2] <= sum2;
  end

endmodule

// File: tb/tb_spec_acc_param.sv
// tb/tb_spec_acc_param.sv - randomized self-checking bench for spec_acc_param against a frame-level model.
module tb_spec_acc_param;

  localparam longint MAXV = (64'd1 << 17) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  num_acc;
  logic        in_valid;
  logic [3:0]  in_bin;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_sof;
  logic [3:0]  out_bin;
  logic [16:0] out_data;
  logic [7:0]  int_cnt;

  spec_acc_param #(.DATA_W(16), .ACC_W(17), .ADDR_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .num_acc(num_acc), .in_valid(in_valid), .in_bin(in_bin),
    .in_data(in_data), .out_valid(out_valid), .out_sof(out_sof), .out_bin(out_bin),
    .out_data(out_data), .int_cnt(int_cnt)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     passed = 0;
  int     fails = 0;

  bit     m_aligned;
  int     m_fidx;
  int     m_n;
  longint m_acc [16];

  bit     pe_v, pe_sof;
  int     pe_bin;
  longint pe_data;
  int     exp_int;
  longint last_out;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output for one presented sample, from the integration rules.
  task automatic model(bit v, int bin, longint data, output bit ev, output bit esof,
                       output int ebin, output longint edata);
    longint s;
    ev = 0; esof = 0; ebin = 0; edata = 0;
    if (!v) return;
    if (bin == 0) begin
      if (!m_aligned || m_fidx == m_n - 1) begin
        m_aligned = 1;
        m_fidx = 0;
        m_n = (num_acc == 0) ? 1 : int'(num_acc);
      end else begin
        m_fidx++;
      end
    end
    if (!m_aligned) return;
    if (m_fidx == 0) begin
      m_acc[bin] = data;
    end else begin
      s = m_acc[bin] + data;
`ifdef ACC_SAT_EN
      if (s > MAXV) s = MAXV;
`else
      s = s % (MAXV + 1);
`endif
      m_acc[bin] = s;
    end
    if (m_fidx == m_n - 1) begin
      ev = 1; esof = (bin == 0); ebin = bin; edata = m_acc[bin];
    end
  endtask

  task automatic step(bit v, int bin, longint data);
    bit nv, nsof;
    int nbin;
    longint ndata;
    in_valid = v;
    in_bin   = bin[3:0];
    in_data  = data[15:0];
    model(v, bin, data, nv, nsof, nbin, ndata);
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(pe_v));
    check("out_sof", 64'(out_sof), 64'(pe_sof));
    check("out_bin", 64'(out_bin), 64'(pe_bin));
    check("out_data", 64'(out_data), 64'(pe_data));
    check("int_cnt", 64'(int_cnt), 64'(exp_int));
    if (pe_v && pe_sof) exp_int = (exp_int + 1) % 256;
    if (out_valid) last_out = out_data;
    pe_v = nv; pe_sof = nsof; pe_bin = nbin; pe_data = ndata;
  endtask

  task automatic gap();
    step(0, int'($urandom_range(15)), longint'($urandom_range(65535)));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) gap();
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; in_bin = 0; in_data = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    m_aligned = 0; m_fidx = 0; m_n = 0;
    pe_v = 0; pe_sof = 0; pe_bin = 0; pe_data = 0; exp_int = 0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sof", 64'(out_sof), 64'd0);
    check("rst_out_bin", 64'(out_bin), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_int_cnt", 64'(int_cnt), 64'd0);
  endtask

  task automatic frames(int n, longint fixed);
    for (int f = 0; f < n; f++)
      for (int b = 0; b < 4; b++)
        step(1, b, (fixed >= 0) ? fixed : longint'(b + 1));
  endtask

  initial begin
    rst = 1; num_acc = 0; in_valid = 0; in_bin = 0; in_data = 0;
    last_out = 0;

    // Pre-alignment samples ignored; 3-frame integration of 1,2,3,4.
    do_reset();
    num_acc = 3;
    step(1, 5, 100);
    step(1, 6, 200);
    frames(3, -1);
    idle(3);
    check("t1_int_cnt", 64'(int_cnt), 64'd1);
    check("t1_last_out", 64'(last_out), 64'd12);

    // num_acc 0 and 1 both pass frames straight through.
    do_reset();
    num_acc = 0;
    frames(2, 7);
    idle(3);
    check("t2a_int_cnt", 64'(int_cnt), 64'd2);
    check("t2a_last_out", 64'(last_out), 64'd7);
    do_reset();
    num_acc = 1;
    frames(2, 7);
    idle(3);
    check("t2b_int_cnt", 64'(int_cnt), 64'd2);

    // num_acc change mid-integration takes effect at the next integration.
    do_reset();
    num_acc = 2;
    step(1, 0, 1);
    step(1, 1, 2);
    num_acc = 4;
    step(1, 2, 3);
    step(1, 3, 4);
    frames(5, -1);
    idle(3);
    check("t3_int_cnt", 64'(int_cnt), 64'd2);
    check("t3_last_out", 64'(last_out), 64'd16);

    // Random 50% input gaps.
    do_reset();
    num_acc = 4;
    for (int f = 0; f < 8; f++)
      for (int b = 0; b < 4; b++) begin
        while ($urandom_range(1) == 1) gap();
        step(1, b, longint'(b + 1));
      end
    idle(3);
    check("t4_int_cnt", 64'(int_cnt), 64'd2);
    check("t4_last_out", 64'(last_out), 64'd16);

    // Overflow at ACC_W = 17.
    do_reset();
    num_acc = 3;
    frames(3, 64'hFFFF);
    idle(3);
`ifdef ACC_SAT_EN
    check("t5_overflow", 64'(last_out), 64'h1FFFF);
`else
    check("t5_overflow", 64'(last_out), 64'h0FFFD);
`endif

    // Reset mid-integration, resume mid-frame.
    do_reset();
    num_acc = 4;
    for (int b = 0; b < 4; b++) step(1, b, longint'($urandom_range(65535)));
    step(1, 0, 999);
    step(1, 1, 999);
    do_reset();
    step(1, 2, 555);
    step(1, 3, 555);
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 4; b++) step(1, b, longint'($urandom_range(1000)));
    idle(3);
    check("t6_int_cnt", 64'(int_cnt), 64'd1);

    // Random integration lengths, data and gaps, including short repeated-bin-0 frames.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      num_acc = 8'($urandom_range(5));
      for (int f = 0; f < 6; f++) begin
        int len;
        len = (f == 2) ? 3 : 4;
        for (int b = 0; b < len; b++) begin
          if ($urandom_range(3) == 0) gap();
          step(1, b, longint'($urandom_range(65535)));
        end
      end
    end
    idle(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
